dmem_seq: RTL and testbench

DMEM_SEQ -- requirements
Module: dmem_seq

---
 rtl/y86_pkg.sv | 42 ++++
 rtl/dmem_word_ram.sv | 34 +++
 rtl/dmem_seq.sv | 140 ++++++++++++++
 tb/tb_dmem_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg - shared Y86-64 definitions for the data-memory sequencer.
//   icode constants for the memory-touching instructions, the sequencer state
//   type, and a decoder mapping an icode onto its memory operation.
package y86_pkg;

    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        DONE = 2'd3
    } dmem_state_t;

    // en: touches storage; wr: store; addr_a: address from valA (else valE);
    // data_p: write data from valP (else valA).
    typedef struct packed {
        logic en;
        logic wr;
        logic addr_a;
        logic data_p;
    } mem_op_t;

    function automatic mem_op_t decode_op(input logic [3:0] icode);
        mem_op_t op;
        op = '0;
        case (icode)
            IRMMOVQ, IPUSHQ: op = '{en: 1'b1, wr: 1'b1, addr_a: 1'b0, data_p: 1'b0};
            ICALL:           op = '{en: 1'b1, wr: 1'b1, addr_a: 1'b0, data_p: 1'b1};
            IMRMOVQ:         op = '{en: 1'b1, wr: 1'b0, addr_a: 1'b0, data_p: 1'b0};
            IPOPQ, IRET:     op = '{en: 1'b1, wr: 1'b0, addr_a: 1'b1, data_p: 1'b0};
            default:         op = '0;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/dmem_word_ram.sv
// dmem_word_ram - DEPTH_WORDS x 64-bit storage array.
//   i_clk    : write clock
//   i_we     : write enable
//   i_be     : per-byte write enable (bit b covers bits 8b+7:8b)
//   i_addr   : word index for both read and write
//   i_wdata  : write data
//   o_rdata  : asynchronous read data of word i_addr
module dmem_word_ram #(
    parameter int DEPTH_WORDS = 512,
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [7:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [63:0]   i_wdata,
    output logic [63:0]   o_rdata
);

    logic [63:0] r_mem [DEPTH_WORDS];

    // NOTE: storage has no reset; contents survive rst_n and an array reset
    // would also prevent mapping onto RAM macros.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 8; b++) begin
                if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_seq.sv
// dmem_seq - Y86-64 data-memory access sequencer.
//   Accepts one access per handshake (req && ready), decodes the icode into a
//   load/store, range-checks the byte address and drives dmem_word_ram.
//   Optional macro DMEM_UNALIGNED_EN: unaligned accesses split over two words
//   (IDLE->ACC0->ACC1->DONE); when undefined they are reported as faults.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req, icode            : request and instruction code (sampled when ready)
//   valA, valE, valP      : operand values from execute
//   ready                 : idle, request will be accepted
//   done                  : one-cycle completion pulse
//   valM, dmem_error      : read data / fault flag, held until the next done
module dmem_seq
    import y86_pkg::*;
#(
    parameter int DEPTH_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic        ready,
    output logic        done,
    output logic [63:0] valM,
    output logic        dmem_error
);

    localparam int          AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [64:0] BYTES = 65'(DEPTH_WORDS) * 65'd8;

    dmem_state_t r_state, w_next;
    mem_op_t     r_op;
    logic [63:0] r_addr, r_wdata, r_lo, r_valM;
    logic        r_err;

    logic          w_fault, w_split, w_rd_ok, w_unaligned, w_ram_we;
    logic [64:0]   w_end;
    logic [AW-1:0] w_word, w_ram_addr;
    logic [127:0]  w_wshift;
    logic [15:0]   w_be16;
    logic [7:0]    w_ram_be;
    logic [63:0]   w_ram_wdata, w_ram_rdata, w_rd_join;
    mem_op_t       w_op_in;

    assign w_op_in = decode_op(icode);

    // 65-bit sum so that an address whose +7 wraps lands above BYTES.
    assign w_end       = {1'b0, r_addr} + 65'd7;
    assign w_unaligned = (r_addr[2:0] != 3'd0);
`ifdef DMEM_UNALIGNED_EN
    assign w_fault = r_op.en && (w_end >= BYTES);
    assign w_split = r_op.en && !w_fault && w_unaligned;
`else
    assign w_fault = r_op.en && ((w_end >= BYTES) || w_unaligned);
    assign w_split = 1'b0;
`endif
    assign w_rd_ok = r_op.en && !r_op.wr && !w_fault;

    // Byte lane placement: the lower 64 bits go to word w, the upper to w+1.
    assign w_word   = r_addr[AW+2:3];
    assign w_wshift = {64'd0, r_wdata} << {r_addr[2:0], 3'b000};
    assign w_be16   = {8'd0, 8'hFF} << r_addr[2:0];

    assign w_ram_addr  = (r_state == ACC1) ? w_word + AW'(1) : w_word;
    assign w_ram_be    = (r_state == ACC1) ? w_be16[15:8]    : w_be16[7:0];
    assign w_ram_wdata = (r_state == ACC1) ? w_wshift[127:64] : w_wshift[63:0];
    assign w_ram_we    = r_op.en && r_op.wr && !w_fault &&
                         ((r_state == ACC0) || (r_state == ACC1));

    // Unaligned read: high word (live) concatenated with low word (held).
    assign w_rd_join = 64'({w_ram_rdata, r_lo} >> {r_addr[2:0], 3'b000});

    dmem_word_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .i_clk   (clk),
        .i_we    (w_ram_we),
        .i_be    (w_ram_be),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // NOTE: w_next is defaulted before the case so no path infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (req) w_next = ACC0;
            ACC0: w_next = w_split ? ACC1 : DONE;
            ACC1: w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_lo    <= '0;
            r_valM  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (req) begin
                    r_op    <= w_op_in;
                    r_addr  <= w_op_in.addr_a ? valA : valE;
                    r_wdata <= w_op_in.data_p ? valP : valA;
                end
                ACC0: begin
                    r_lo <= w_ram_rdata;
                    if (!w_split) begin
                        r_valM <= w_rd_ok ? w_ram_rdata : 64'd0;
                        r_err  <= w_fault;
                    end
                end
                ACC1: begin
                    r_valM <= w_rd_ok ? w_rd_join : 64'd0;
                    r_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign ready      = (r_state == IDLE);
    assign done       = (r_state == DONE);
    assign valM       = r_valM;
    assign dmem_error = r_err;

endmodule

// File: tb/tb_dmem_seq.sv
// tb_dmem_seq - directed self-checking bench for dmem_seq (default depth 512).
module tb_dmem_seq;

    localparam int          DEPTH_WORDS = 512;
    localparam logic [63:0] BYTES       = 64'(DEPTH_WORDS * 8);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [3:0]  icode;
    logic [63:0] valA, valE, valP;
    logic        ready, done, dmem_error;
    logic [63:0] valM;

    int checks = 0;
    int fails  = 0;

    logic [63:0] exp40, exp48;
    int          pulses;

    always #5 clk = ~clk;

    dmem_seq #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .icode      (icode),
        .valA       (valA),
        .valE       (valE),
        .valP       (valP),
        .ready      (ready),
        .done       (done),
        .valM       (valM),
        .dmem_error (dmem_error)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // One handshake; latency counts rising edges from acceptance to done.
    task automatic access(input string tag, input logic [3:0] ic,
                          input logic [63:0] a, input logic [63:0] e, input logic [63:0] p,
                          input int lat, input logic exp_err,
                          input logic chk_m, input logic [63:0] exp_m);
        int k;
        @(negedge clk);
        check({tag, ".ready"}, 64'(ready), 64'd1);
        req = 1'b1; icode = ic; valA = a; valE = e; valP = p;
        @(posedge clk); #1;
        // Scramble inputs after acceptance; the captured access must not change.
        req = 1'b0; icode = 4'h0; valA = '1; valE = '1; valP = '1;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!done && k < 4);
        check({tag, ".lat"}, 64'(k), 64'(lat));
        check({tag, ".err"}, 64'(dmem_error), 64'(exp_err));
        if (chk_m) check({tag, ".valM"}, valM, exp_m);
        @(posedge clk); #1;
        check({tag, ".pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; icode = 4'h0; valA = '0; valE = '0; valP = '0;
        #12;
        check("rst.done", 64'(done), 64'd0);
        check("rst.valM", valM, 64'd0);
        check("rst.err",  64'(dmem_error), 64'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        check("rst.ready", 64'(ready), 64'd1);

        // Aligned write/read, call/ret.
        access("wr40", 4'h4, 64'h1122334455667788, 64'h40, 64'h0, 1, 1'b0, 1'b0, 64'h0);
        access("rd40", 4'h5, 64'h0, 64'h40, 64'h0, 1, 1'b0, 1'b1, 64'h1122334455667788);
        access("call", 4'h8, 64'h0, 64'h1F8, 64'h123, 1, 1'b0, 1'b0, 64'h0);
        access("ret",  4'h9, 64'h1F8, 64'h0, 64'h0, 1, 1'b0, 1'b1, 64'h123);

        // Range boundaries and faults.
        access("wr0",     4'h4, 64'h0BAD_F00D_CAFE_0001, 64'h0, 64'h0, 1, 1'b0, 1'b0, 64'h0);
        access("wrFF8",   4'h4, 64'h5A5A_0000_FFFF_A5A5, BYTES - 8, 64'h0, 1, 1'b0, 1'b0, 64'h0);
        access("rdFF8",   4'h5, 64'h0, BYTES - 8, 64'h0, 1, 1'b0, 1'b1, 64'h5A5A_0000_FFFF_A5A5);
        access("flt_rd",  4'h5, 64'h0, BYTES - 4, 64'h0, 1, 1'b1, 1'b1, 64'h0);
        access("flt_wr",  4'h4, 64'hDEAD_BEEF_DEAD_BEEF, BYTES, 64'h0, 1, 1'b1, 1'b1, 64'h0);
        access("rd0",     4'h5, 64'h0, 64'h0, 64'h0, 1, 1'b0, 1'b1, 64'h0BAD_F00D_CAFE_0001);
        access("flt_ovf", 4'h5, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1, 1'b1, 1'b1, 64'h0);
        access("flt_top", 4'h5, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1, 1'b1, 1'b1, 64'h0);

        // Unaligned push/pop across words 0x40 and 0x48.
        access("wr48", 4'h4, 64'h99AABBCCDDEEFF00, 64'h48, 64'h0, 1, 1'b0, 1'b0, 64'h0);
`ifdef DMEM_UNALIGNED_EN
        access("push_u", 4'hA, 64'hAABBCCDDEEFF0011, 64'h43, 64'h0, 2, 1'b0, 1'b0, 64'h0);
        access("pop_u",  4'hB, 64'h43, 64'h0, 64'h0, 2, 1'b0, 1'b1, 64'hAABBCCDDEEFF0011);
        exp40 = 64'hDDEEFF0011667788;
        exp48 = 64'h99AABBCCDDAABBCC;
`else
        access("push_u", 4'hA, 64'hAABBCCDDEEFF0011, 64'h43, 64'h0, 1, 1'b1, 1'b1, 64'h0);
        access("pop_u",  4'hB, 64'h43, 64'h0, 64'h0, 1, 1'b1, 1'b1, 64'h0);
        exp40 = 64'h1122334455667788;
        exp48 = 64'h99AABBCCDDEEFF00;
`endif
        access("rd40u", 4'h5, 64'h0, 64'h40, 64'h0, 1, 1'b0, 1'b1, exp40);
        access("rd48u", 4'h5, 64'h0, 64'h48, 64'h0, 1, 1'b0, 1'b1, exp48);

        // Non-memory icode: no storage access, valM=0.
        access("opq",   4'h6, 64'h5555, 64'h40, 64'h7777, 1, 1'b0, 1'b1, 64'h0);
        access("rd40o", 4'h5, 64'h0, 64'h40, 64'h0, 1, 1'b0, 1'b1, exp40);

        // Handshake: req held high; inputs changed during ACC0.
        @(negedge clk);
        req = 1'b1; icode = 4'h4; valA = 64'hA1A1_0000_1111_2222; valE = 64'h50;
        @(negedge clk);
        check("hs.acc0_ready", 64'(ready), 64'd0);
        valA = 64'hA2A2_3333_4444_5555; icode = 4'h5;
        @(negedge clk);
        check("hs.done",       64'(done),  64'd1);
        check("hs.done_ready", 64'(ready), 64'd0);
        @(negedge clk);
        check("hs.idle_ready", 64'(ready), 64'd1);
        @(negedge clk);
        req = 1'b0;
        check("hs.acc0_done", 64'(done), 64'd0);
        @(negedge clk);
        check("hs.rd_done", 64'(done), 64'd1);
        check("hs.rd_valM", valM, 64'hA1A1_0000_1111_2222);
        @(negedge clk);

        // Reset during the in-flight access (ACC1 when split, else ACC0).
        access("wr60", 4'h4, 64'h0, 64'h60, 64'h0, 1, 1'b0, 1'b0, 64'h0);
        access("wr68", 4'h4, 64'h0, 64'h68, 64'h0, 1, 1'b0, 1'b0, 64'h0);
        access("rd40r", 4'h5, 64'h0, 64'h40, 64'h0, 1, 1'b0, 1'b1, exp40);
        @(negedge clk);
        req = 1'b1; icode = 4'hA; valA = 64'h0102030405060708;
`ifdef DMEM_UNALIGNED_EN
        valE = 64'h64;
        @(posedge clk); #1; req = 1'b0;
        @(posedge clk);
`else
        valE = 64'h60;
        @(posedge clk); #1; req = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b0; #1;
        check("ab.done",  64'(done),  64'd0);
        check("ab.valM",  valM,       64'd0);
        check("ab.ready", 64'(ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("ab.pulses", 64'(pulses), 64'd0);
        check("ab.ready2", 64'(ready),  64'd1);
`ifdef DMEM_UNALIGNED_EN
        access("rd60", 4'h5, 64'h0, 64'h60, 64'h0, 1, 1'b0, 1'b1, 64'h0506070800000000);
`else
        access("rd60", 4'h5, 64'h0, 64'h60, 64'h0, 1, 1'b0, 1'b1, 64'h0);
`endif
        access("rd68", 4'h5, 64'h0, 64'h68, 64'h0, 1, 1'b0, 1'b1, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
